// File: rtl/div_iter_unit.sv
// Iterative restoring divider: one quotient bit per clock, MSB first, IDLE/RUN/FIN FSM.
// Define DIV_ITER_SIGNED_EN for two's-complement truncating division; the default build is unsigned.
module div_iter_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             w_last;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvsr;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remd;
  logic             r_div_zero;

  logic [WIDTH:0]   w_partial;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_q_step;
  logic [WIDTH-1:0] w_rem_step;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_q_res;
  logic [WIDTH-1:0] w_r_res;

  // Handshake: start is a request sampled on each rising edge and accepted only in IDLE or FIN;
  // there is no back-pressure. done pulses for one cycle per accepted start, results hold until the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_last   = (r_state == S_RUN) && (r_cnt == CW'(WIDTH - 1));
    case (r_state)
      S_IDLE, S_FIN: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = (divisor == '0) ? S_FIN : S_RUN;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_last) w_next = S_FIN;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Partial remainder is always below the divisor, so a WIDTH+1-bit difference cannot overflow.
  assign w_partial  = {r_rem, r_q[WIDTH-1]};
  assign w_trial    = w_partial - {1'b0, r_dvsr};
  assign w_q_step   = {r_q[WIDTH-2:0], ~w_trial[WIDTH]};
  assign w_rem_step = w_trial[WIDTH] ? w_partial[WIDTH-1:0] : w_trial[WIDTH-1:0];

`ifdef DIV_ITER_SIGNED_EN
  logic r_q_neg;
  logic r_r_neg;

  assign w_a_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign w_b_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign w_q_res = r_q_neg ? -w_q_step   : w_q_step;
  assign w_r_res = r_r_neg ? -w_rem_step : w_rem_step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
    end else if (w_accept) begin
      r_q_neg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      r_r_neg <= dividend[WIDTH-1];
    end
  end
`else
  assign w_a_mag = dividend;
  assign w_b_mag = divisor;
  assign w_q_res = w_q_step;
  assign w_r_res = w_rem_step;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_q        <= '0;
      r_rem      <= '0;
      r_dvsr     <= '0;
      r_quot     <= '0;
      r_remd     <= '0;
      r_div_zero <= 1'b0;
    end else if (w_accept) begin
      r_cnt      <= '0;
      r_q        <= w_a_mag;
      r_rem      <= '0;
      r_dvsr     <= w_b_mag;
      r_div_zero <= (divisor == '0);
      if (divisor == '0) begin
        r_quot <= '1;
        r_remd <= dividend;
      end
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt + CW'(1);
      r_q   <= w_q_step;
      r_rem <= w_rem_step;
      if (w_last) begin
        r_quot <= w_q_res;
        r_remd <= w_r_res;
      end
    end
  end

  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_FIN);
  assign quotient  = r_quot;
  assign remainder = r_remd;
  assign div_zero  = r_div_zero;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_div_iter_unit.sv
// Directed bench for div_iter_unit: vector table plus hand-written back-to-back, reset and ignored-start sequences.
module tb_div_iter_unit;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;
  logic [1:0]   dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  div_iter_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .quotient (quotient),
    .remainder(remainder),
    .div_zero (div_zero),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
  } vec_t;

  vec_t vtab[11];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // From a negedge, step whole cycles until done is seen or the budget runs out.
  task automatic wait_done(output int lat, output int busy_n);
    lat = 0;
    busy_n = 0;
    while (!done && lat < 100) begin
      if (busy) busy_n++;
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                        input int elat);
    int lat;
    int busy_n;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, busy_n);
    check({nm, "_done"}, 32'(done), 32'd1);
    check({nm, "_lat"}, 32'(lat), 32'(elat));
    check({nm, "_busy_cycles"}, 32'(busy_n), 32'(elat));
    check({nm, "_busy_at_done"}, 32'(busy), 32'd0);
    check({nm, "_q"}, 32'(quotient), 32'(eq));
    check({nm, "_r"}, 32'(remainder), 32'(er));
    check({nm, "_dz"}, 32'(div_zero), 32'(edz));
    @(posedge clk);
    @(negedge clk);
    check({nm, "_done_pulse"}, 32'(done), 32'd0);
    check({nm, "_idle"}, 32'(dbg_state), 32'd0);
    check({nm, "_q_hold"}, 32'(quotient), 32'(eq));
    check({nm, "_r_hold"}, 32'(remainder), 32'(er));
    check({nm, "_dz_hold"}, 32'(div_zero), 32'(edz));
  endtask

  initial begin
    int lat;
    int busy_n;
    int t1;
    int t2;
    int extra;

    vtab[0]  = '{a: 16'd100,  b: 16'd7,    q: 16'd14,   r: 16'd2,    dz: 1'b0, lat: 16};
    vtab[1]  = '{a: 16'h1234, b: 16'h0000, q: 16'hFFFF, r: 16'h1234, dz: 1'b1, lat: 0};
    vtab[2]  = '{a: 16'd5,    b: 16'd3,    q: 16'd1,    r: 16'd2,    dz: 1'b0, lat: 16};
    vtab[3]  = '{a: 16'd3,    b: 16'd5,    q: 16'd0,    r: 16'd3,    dz: 1'b0, lat: 16};
    vtab[4]  = '{a: 16'hABCD, b: 16'h0001, q: 16'hABCD, r: 16'h0000, dz: 1'b0, lat: 16};
    vtab[5]  = '{a: 16'hFFFF, b: 16'hFFFF, q: 16'h0001, r: 16'h0000, dz: 1'b0, lat: 16};
    vtab[7]  = '{a: 16'd0,    b: 16'd9,    q: 16'd0,    r: 16'd0,    dz: 1'b0, lat: 16};
    vtab[10] = '{a: 16'h0000, b: 16'h0000, q: 16'hFFFF, r: 16'h0000, dz: 1'b1, lat: 0};
`ifdef DIV_ITER_SIGNED_EN
    vtab[6]  = '{a: 16'hFFFF, b: 16'h0002, q: 16'h0000, r: 16'hFFFF, dz: 1'b0, lat: 16};
    vtab[8]  = '{a: 16'hFF9C, b: 16'h0007, q: 16'hFFF2, r: 16'hFFFE, dz: 1'b0, lat: 16};
    vtab[9]  = '{a: 16'h8000, b: 16'hFFFF, q: 16'h8000, r: 16'h0000, dz: 1'b0, lat: 16};
`else
    vtab[6]  = '{a: 16'hFFFF, b: 16'h0002, q: 16'h7FFF, r: 16'h0001, dz: 1'b0, lat: 16};
    vtab[8]  = '{a: 16'hFF9C, b: 16'h0007, q: 16'h2484, r: 16'h0000, dz: 1'b0, lat: 16};
    vtab[9]  = '{a: 16'h8000, b: 16'hFFFF, q: 16'h0000, r: 16'h8000, dz: 1'b0, lat: 16};
`endif

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_q", 32'(quotient), 32'd0);
    check("rst_r", 32'(remainder), 32'd0);
    check("rst_dz", 32'(div_zero), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_op($sformatf("vec%0d", i), vtab[i].a, vtab[i].b, vtab[i].q, vtab[i].r,
             vtab[i].dz, vtab[i].lat);
    end

    // Back-to-back: start held high, second op accepted in the done cycle
    @(negedge clk);
    dividend = 16'd200;
    divisor  = 16'd10;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dividend = 16'd9;
    divisor  = 16'd4;
    wait_done(lat, busy_n);
    t1 = cyc;
    check("b2b_done1", 32'(done), 32'd1);
    check("b2b_lat1", 32'(lat), 32'd16);
    check("b2b_q1", 32'(quotient), 32'd20);
    check("b2b_r1", 32'(remainder), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("b2b_reaccept_busy", 32'(busy), 32'd1);
    wait_done(lat, busy_n);
    t2 = cyc;
    start = 1'b0;
    check("b2b_done2", 32'(done), 32'd1);
    check("b2b_gap", 32'(t2 - t1), 32'd17);
    check("b2b_q2", 32'(quotient), 32'd2);
    check("b2b_r2", 32'(remainder), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("b2b_idle", 32'(dbg_state), 32'd0);

    // Asynchronous reset in cycle 8 of a RUN
    @(negedge clk);
    dividend = 16'd100;
    divisor  = 16'd7;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("mid_busy_before", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_q", 32'(quotient), 32'd0);
    check("arst_r", 32'(remainder), 32'd0);
    check("arst_dz", 32'(div_zero), 32'd0);
    check("arst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst", 16'd5, 16'd3, 16'd1, 16'd2, 1'b0, 16);

    // Start pulsed during RUN must be ignored
    @(negedge clk);
    dividend = 16'd50;
    divisor  = 16'd3;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    dividend = 16'd9;
    divisor  = 16'd9;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, busy_n);
    check("ign_done", 32'(done), 32'd1);
    check("ign_lat", 32'(lat + 5), 32'd16);
    check("ign_q", 32'(quotient), 32'd16);
    check("ign_r", 32'(remainder), 32'd2);
    extra = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) extra++;
    end
    check("ign_extra_done", 32'(extra), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
